// File: rtl/serial_tx_arbiter_if.sv
// rtl/serial_tx_arbiter_if.sv - requester and UART handshake bundle for serial_tx_arbiter
interface serial_tx_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   valid;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   last;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   abort;
  logic              txBusy;
  logic              txStart;
  logic [7:0]        txData;
  logic              busy;

  modport master (
    output req, valid, data, last, txBusy,
    input  ack, grant, abort, txStart, txData, busy
  );

  modport slave (
    input  req, valid, data, last, txBusy,
    output ack, grant, abort, txStart, txData, busy
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - round-robin packet arbiter feeding one UART transmitter
// Holds a requester for a whole packet; releases on last byte, req drop or stall timeout.
module serial_tx_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 4096
) (
  input logic                clk,
  input logic                rst,
  serial_tx_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SEND, STROBE, SETTLE} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] g;
  logic [IW-1:0] g_next;
  logic [SW-1:0] stall;
  logic          last_q;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] jj;
  int            j;

  // Scan downwards in offset so the smallest offset from ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    j          = 0;
    jj         = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (bus.req[jj]) begin
        pick_valid = 1'b1;
        pick_idx   = jj;
      end
    end
  end

  assign g_next = (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      g           <= '0;
      stall       <= '0;
      last_q      <= 1'b0;
      bus.grant   <= '0;
      bus.ack     <= '0;
      bus.abort   <= '0;
      bus.txStart <= 1'b0;
      bus.txData  <= 8'h00;
      bus.busy    <= 1'b0;
    end else begin
      bus.ack     <= '0;
      bus.abort   <= '0;
      bus.txStart <= 1'b0;
      case (state)
        IDLE: begin
          bus.grant <= '0;
          bus.busy  <= 1'b0;
          if (pick_valid) begin
            g         <= pick_idx;
            bus.grant <= NREQ'(1) << pick_idx;
            bus.busy  <= 1'b1;
            stall     <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (bus.valid[g] && !bus.txBusy) begin
            bus.txData  <= bus.data[8*g +: 8];
            bus.txStart <= 1'b1;
            bus.ack     <= NREQ'(1) << g;
            last_q      <= bus.last[g];
            stall       <= '0;
            state       <= STROBE;
          end else if (!bus.valid[g]) begin
            // A dropped request is a clean release; only a stalled live request aborts.
            if (!bus.req[g] || stall == SW'(TIMEOUT - 1)) begin
              if (bus.req[g]) bus.abort <= NREQ'(1) << g;
              bus.grant <= '0;
              bus.busy  <= 1'b0;
              ptr       <= g_next;
              state     <= IDLE;
            end else begin
              stall <= stall + 1'b1;
            end
          end
        end
        STROBE: state <= SETTLE;
        SETTLE: begin
          if (last_q) begin
            bus.grant <= '0;
            bus.busy  <= 1'b0;
            ptr       <= g_next;
            state     <= IDLE;
          end else begin
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - directed vector and sequence bench for serial_tx_arbiter
module tb_serial_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_tx_arbiter_if #(.NREQ(3)) bus ();
  serial_tx_arbiter #(.NREQ(3), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] req;
    logic [2:0] valid;
    logic [2:0] last;
    logic [7:0] dat;
    logic       txb;
    logic [2:0] e_grant;
    logic [2:0] e_ack;
    logic       e_start;
    logic [7:0] e_data;
    logic       e_busy;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, bus.grant, bus.ack, bus.abort, bus.txStart, bus.txData, bus.busy};
  endfunction

  task automatic idle_inputs();
    bus.req    = '0;
    bus.valid  = '0;
    bus.last   = '0;
    bus.data   = '0;
    bus.txBusy = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [2:0] seen[4];
  logic [2:0] exp_order[4];
  logic [2:0] prev;
  int         ns;
  int         bad;

  initial begin
    vecs[0]  = '{3'b000, 3'b000, 3'b000, 8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{3'b001, 3'b001, 3'b000, 8'h41, 1'b0, 3'b001, 3'b000, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{3'b001, 3'b001, 3'b000, 8'h41, 1'b0, 3'b001, 3'b001, 1'b1, 8'h41, 1'b1};
    vecs[3]  = '{3'b001, 3'b001, 3'b000, 8'h42, 1'b0, 3'b001, 3'b000, 1'b0, 8'h41, 1'b1};
    vecs[4]  = '{3'b001, 3'b001, 3'b000, 8'h42, 1'b0, 3'b001, 3'b000, 1'b0, 8'h41, 1'b1};
    vecs[5]  = '{3'b001, 3'b001, 3'b000, 8'h42, 1'b0, 3'b001, 3'b001, 1'b1, 8'h42, 1'b1};
    vecs[6]  = '{3'b001, 3'b001, 3'b001, 8'h43, 1'b0, 3'b001, 3'b000, 1'b0, 8'h42, 1'b1};
    vecs[7]  = '{3'b001, 3'b001, 3'b001, 8'h43, 1'b0, 3'b001, 3'b000, 1'b0, 8'h42, 1'b1};
    vecs[8]  = '{3'b001, 3'b001, 3'b001, 8'h43, 1'b0, 3'b001, 3'b001, 1'b1, 8'h43, 1'b1};
    vecs[9]  = '{3'b000, 3'b000, 3'b000, 8'h00, 1'b0, 3'b001, 3'b000, 1'b0, 8'h43, 1'b1};
    vecs[10] = '{3'b000, 3'b000, 3'b000, 8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 8'h43, 1'b0};
    vecs[11] = '{3'b000, 3'b000, 3'b000, 8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 8'h43, 1'b0};
    exp_order[0] = 3'b001;
    exp_order[1] = 3'b010;
    exp_order[2] = 3'b100;
    exp_order[3] = 3'b001;

    // Reset state and single-requester three-byte packet.
    idle_inputs();
    #2;
    check("reset_outputs", outs(), 32'd0);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.req    = vecs[i].req;
      bus.valid  = vecs[i].valid;
      bus.last   = vecs[i].last;
      bus.data   = {16'h0000, vecs[i].dat};
      bus.txBusy = vecs[i].txb;
      step();
      check($sformatf("vec%0d", i), outs(),
            {13'd0, vecs[i].e_grant, vecs[i].e_ack, 3'b000, vecs[i].e_start,
             vecs[i].e_data, vecs[i].e_busy});
    end

    // Simultaneous requests; requester 0 re-requests immediately.
    do_reset();
    bus.req   = 3'b111;
    bus.valid = 3'b111;
    bus.last  = 3'b111;
    bus.data  = {8'hC3, 8'hB2, 8'hA1};
    for (int i = 0; i < 4; i++) seen[i] = 3'b000;
    ns   = 0;
    prev = 3'b000;
    for (int c = 0; c < 200 && ns < 4; c++) begin
      step();
      if (bus.grant != 3'b000 && prev == 3'b000) begin
        seen[ns] = bus.grant;
        ns++;
      end
      prev = bus.grant;
      if (bus.ack[1]) begin bus.req[1] = 1'b0; bus.valid[1] = 1'b0; end
      if (bus.ack[2]) begin bus.req[2] = 1'b0; bus.valid[2] = 1'b0; end
    end
    check("rr_grant_count", ns, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), seen[i], exp_order[i]);

    // txBusy held high for 20 cycles inside a packet.
    do_reset();
    bus.req    = 3'b001;
    bus.valid  = 3'b001;
    bus.last   = 3'b001;
    bus.data   = {16'h0000, 8'h55};
    bus.txBusy = 1'b1;
    step();
    check("busy_grant", bus.grant, 3'b001);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.txStart) bad++;
    end
    check("busy_no_start", bad, 0);
    bus.txBusy = 1'b0;
    step();
    check("busy_release_start", {bus.txStart, bus.txData}, {1'b1, 8'h55});

    // Stall timeout on requester 1, then clean release by req drop.
    do_reset();
    bus.req = 3'b010;
    step();
    check("to_grant", bus.grant, 3'b010);
    bus.req = 3'b111;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (bus.abort != 3'b000 || bus.grant != 3'b010) bad++;
    end
    check("to_before_abort", bad, 0);
    step();
    check("to_abort", {bus.abort, bus.grant}, {3'b010, 3'b000});
    bus.req = 3'b101;
    step();
    check("to_next_grant", {bus.abort, bus.grant}, {3'b000, 3'b100});
    bus.req = 3'b001;
    step();
    check("drop_release", {bus.abort, bus.grant, bus.busy}, {3'b000, 3'b000, 1'b0});
    step();
    check("drop_next_grant", bus.grant, 3'b001);

    // Asynchronous reset between byte launches of a longer packet.
    do_reset();
    bus.req   = 3'b001;
    bus.valid = 3'b001;
    bus.data  = {16'h0000, 8'h11};
    step();
    step();
    check("mid_launch", {bus.txStart, bus.txData}, {1'b1, 8'h11});
    bus.data = {16'h0000, 8'h22};
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", outs(), 32'd0);
    bus.req   = 3'b110;
    bus.valid = 3'b110;
    bus.last  = 3'b110;
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_reset_grant", {bus.abort, bus.grant}, {3'b000, 3'b010});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
